// File: rtl/temp_sample_accumulator.sv
// Sums N temperature samples strobed by the sequencing FSM, then forms the rounded
// average and converts it to packed BCD by double dabble, one bit per clock.
//
// state  | meaning
// S_IDLE | cleared, waiting for the first sample
// S_ACCUM| collecting samples until N have been added
// S_ROUND| one cycle: compute rounded average, load converter
// S_CONV | DATA_W cycles of double dabble
// S_DONE | average and BCD held until rst_sum or rst
module temp_sample_accumulator #(
  parameter int DATA_W  = 12,
  parameter int LOG2_N  = 3,
  parameter int BCD_DIG = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rst_sum_i,
  input  logic                 en_sum_i,
  input  logic [DATA_W-1:0]    sample_in_i,
  output logic                 sum_o,
  output logic                 busy_o,
  output logic [DATA_W-1:0]    avg_out_o,
  output logic [4*BCD_DIG-1:0] bcd_out_o,
  output logic                 bcd_valid_o
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int N     = 1 << LOG2_N;
  localparam int BCD_W = 4 * BCD_DIG;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_ROUND, S_CONV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  avg_q, avg_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]        acc_rnd;
  logic [BCD_W-1:0]        work_adj;
  logic [BCD_W+DATA_W-1:0] dabble;

  // acc never exceeds N*(2^DATA_W-1), so adding N/2 cannot wrap
  assign acc_rnd = acc_q + ACC_W'(N / 2);

  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    dabble = {work_adj, shift_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    avg_d   = avg_q;
    shift_d = shift_q;
    work_d  = work_q;
    bit_d   = bit_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    if (rst_sum_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      avg_d   = '0;
      bcd_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (en_sum_i) begin
            acc_d   = acc_q + ACC_W'(sample_in_i);
            count_d = count_q + CNT_W'(1);
            state_d = (count_q == CNT_W'(N - 1)) ? S_ROUND : S_ACCUM;
          end
        end
        S_ROUND: begin
          avg_d   = DATA_W'(acc_rnd >> LOG2_N);
          shift_d = DATA_W'(acc_rnd >> LOG2_N);
          work_d  = '0;
          bit_d   = '0;
          state_d = S_CONV;
        end
        S_CONV: begin
          work_d  = dabble[BCD_W+DATA_W-1:DATA_W];
          shift_d = dabble[DATA_W-1:0];
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bcd_d   = dabble[BCD_W+DATA_W-1:DATA_W];
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      avg_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      avg_q   <= avg_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bit_q   <= bit_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign sum_o       = (count_q == CNT_W'(N - 1)) && (state_q == S_IDLE || state_q == S_ACCUM);
  assign busy_o      = (state_q == S_ROUND) || (state_q == S_CONV);
  assign avg_out_o   = avg_q;
  assign bcd_out_o   = bcd_q;
  assign bcd_valid_o = valid_q;

endmodule

// File: tb/tb_temp_sample_accumulator.sv
// Scoreboard bench for temp_sample_accumulator: stimulus pushes the expected average/BCD
// per completed batch; a negedge monitor pops and compares on each bcd_valid rise.
module tb_temp_sample_accumulator;

  localparam time TCLK = 10;
  localparam int  NS   = 8;
  // Nth sample edge is edge 1; bcd_valid rises on edge DATA_W+2, i.e. DATA_W+1 edges later
  localparam int  LAT  = 13;

  logic        clk = 1'b0;
  logic        rst_n, rst_sum, en_sum;
  logic [11:0] sample;
  logic        sum, busy, bcd_valid;
  logic [11:0] avg;
  logic [15:0] bcd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] avg;
    logic [15:0] bcd;
    time         t0;
  } exp_t;

  exp_t exp_q[$];
  int   mdl[$];
  logic prev_v = 1'b0;
  logic [11:0] last_avg;
  logic [15:0] last_bcd;

  temp_sample_accumulator dut (
    .clk_i(clk), .rst_ni(rst_n), .rst_sum_i(rst_sum), .en_sum_i(en_sum),
    .sample_in_i(sample), .sum_o(sum), .busy_o(busy), .avg_out_o(avg),
    .bcd_out_o(bcd), .bcd_valid_o(bcd_valid)
  );

  always #(TCLK/2) clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bcd_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got bcd_valid=1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("avg", avg, e.avg);
        chk("bcd", bcd, e.bcd);
        chk("latency", ($time - TCLK/2 - e.t0) / TCLK, LAT);
      end
    end
    prev_v = bcd_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    en_sum = 1'b1;
    sample = 12'(s);
    chk("sum", sum, (mdl.size() == NS - 1));
    @(posedge clk);
    mdl.push_back(s);
    if (mdl.size() == NS) begin
      exp_t e;
      int acc = 0;
      foreach (mdl[i]) acc += mdl[i];
      e.avg = 12'((acc + NS/2) / NS);
      e.bcd = to_bcd((acc + NS/2) / NS);
      e.t0  = $time;
      exp_q.push_back(e);
      last_avg = e.avg;
      last_bcd = e.bcd;
      mdl.delete();
    end
    #1;
    en_sum = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (bcd_valid) break;
      step();
    end
    chk("done_seen", bcd_valid, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_avg"}, avg, 0);
    chk({tag, "_bcd"}, bcd, 0);
    chk({tag, "_valid"}, bcd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sum"}, sum, 0);
  endtask

  task automatic clear();
    rst_sum = 1'b1;
    step();
    rst_sum = 1'b0;
    mdl.delete();
    exp_q.delete();
    check_zero("clear");
  endtask

  task automatic run_batch(input int vals[NS], input bit gaps);
    for (int i = 0; i < NS; i++) begin
      send(vals[i]);
      if (gaps) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    int v[NS];
    rst_n = 1'b0; rst_sum = 1'b0; en_sum = 1'b0; sample = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // 8 x 100
    v = '{default: 100};
    for (int i = 0; i < NS; i++) send(v[i]);
    chk("busy_after_nth", busy, 1);
    wait_done();
    chk("avg100", avg, 100);
    chk("bcd100", bcd, 16'h0100);
    // en_sum in DONE is ignored
    en_sum = 1'b1; sample = 12'(777);
    step();
    en_sum = 1'b0;
    repeat (3) step();
    chk("done_hold_avg", avg, last_avg);
    chk("done_hold_bcd", bcd, last_bcd);
    chk("done_hold_valid", bcd_valid, 1);
    chk("done_busy", busy, 0);
    clear();

    // round up and round down
    v = '{0, 0, 0, 0, 0, 0, 0, 4};
    run_batch(v, 1'b0);
    wait_done();
    chk("avg_round_up", avg, 1);
    clear();
    v = '{0, 0, 0, 0, 0, 0, 0, 3};
    run_batch(v, 1'b0);
    wait_done();
    chk("avg_round_down", avg, 0);
    clear();

    // full scale, no wrap
    v = '{default: 4095};
    run_batch(v, 1'b1);
    wait_done();
    chk("avg_max", avg, 4095);
    chk("bcd_max", bcd, 16'h4095);
    clear();

    // abort during CONV
    for (int i = 0; i < NS; i++) v[i] = $urandom_range(0, 4095);
    run_batch(v, 1'b0);
    repeat (4) step();
    chk("busy_conv", busy, 1);
    rst_sum = 1'b1;
    step();
    rst_sum = 1'b0;
    exp_q.delete();
    mdl.delete();
    check_zero("abort");
    repeat (20) step();
    chk("abort_no_valid", bcd_valid, 0);
    for (int i = 0; i < NS; i++) v[i] = $urandom_range(0, 4095);
    run_batch(v, 1'b1);
    wait_done();
    clear();

    // en_sum and rst_sum together at count 7: sample dropped, no ROUND
    for (int i = 0; i < NS - 1; i++) send($urandom_range(0, 4095));
    chk("sum_at_7", sum, 1);
    en_sum = 1'b1; rst_sum = 1'b1; sample = 12'(2000);
    step();
    en_sum = 1'b0; rst_sum = 1'b0;
    mdl.delete();
    check_zero("collide");
    repeat (16) step();
    chk("collide_no_valid", bcd_valid, 0);
    chk("collide_no_busy", busy, 0);
    for (int i = 0; i < NS; i++) v[i] = $urandom_range(0, 4095);
    run_batch(v, 1'b0);
    wait_done();

    // async reset while in DONE, then mid-ACCUM at count 7
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_done");
    exp_q.delete();
    mdl.delete();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NS - 1; i++) send($urandom_range(0, 4095));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_accum");
    mdl.delete();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NS; i++) v[i] = $urandom_range(0, 4095);
    run_batch(v, 1'b1);
    wait_done();
    clear();

    // random batches
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++) v[i] = $urandom_range(0, 4095);
      run_batch(v, 1'b1);
      wait_done();
      clear();
    end

    repeat (2) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
